// File: rtl/mc6502_interrupt_sequencer.sv
// mc6502_interrupt_sequencer
// Interrupt entry sequencer for the MC6502 core. It arbitrates RES, NMI
// (falling edge), BRK and N_IRQ wired-OR maskable IRQ lines. At an
// instruction boundary it pushes PCH, PCL and PSR to the stack, then fetches
// the two-byte vector into PC. An NMI that arrives before the PSR push
// hijacks a BRK/IRQ sequence onto the NMI vector.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_irq_x, i_nmi_x      active-low interrupt requests
//   cs2il_fetch/brk       core sequencer boundary / BRK pulses
//   il2cs_busy/done       core stall and end-of-sequence pulse
//   mc2il_data, il2mc_*   memory controller bus (stack writes, vector reads)
//   rf2il_*               register file S, PSR and PC
//   il2rf_*               register file update strobes and load data
module mc6502_interrupt_sequencer #(
    parameter int          N_IRQ       = 1,
    parameter logic [7:0]  STACK_PAGE  = 8'h01,
    parameter logic [15:0] VECTOR_BASE = 16'hfffa
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] i_irq_x,
    input  logic             i_nmi_x,
    input  logic             cs2il_fetch,
    input  logic             cs2il_brk,
    output logic             il2cs_busy,
    output logic             il2cs_done,
    input  logic [7:0]       mc2il_data,
    output logic [15:0]      il2mc_addr,
    output logic             il2mc_read,
    output logic             il2mc_write,
    output logic [7:0]       il2mc_data,
    input  logic [7:0]       rf2il_s,
    input  logic [7:0]       rf2il_psr,
    input  logic [15:0]      rf2il_pc,
    output logic             il2rf_dec_s,
    output logic             il2rf_set_i,
    output logic [7:0]       il2rf_data,
    output logic             il2rf_set_pcl,
    output logic             il2rf_set_pch
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PUSH_PCH = 3'd1,
        ST_PUSH_PCL = 3'd2,
        ST_PUSH_PSR = 3'd3,
        ST_LOAD_PCL = 3'd4,
        ST_LOAD_PCH = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        SRC_RES = 2'd0,
        SRC_NMI = 2'd1,
        SRC_BRK = 2'd2,
        SRC_IRQ = 2'd3
    } src_t;

    // Vector addresses wrap within 16 bits.
    localparam logic [15:0] VEC_NMI = VECTOR_BASE;
    localparam logic [15:0] VEC_RES = VECTOR_BASE + 16'd2;
    localparam logic [15:0] VEC_IRQ = VECTOR_BASE + 16'd4;

    state_t      state_q, state_d;
    src_t        src_q, src_d;
    logic        nmi_pending_q, nmi_pending_d;
    logic        nmi_prev_q, nmi_prev_d;
    logic        nmi_edge_s;
    logic        nmi_clear_s;
    logic        irq_req_s;
    logic [15:0] vector_s;
    logic [7:0]  push_psr_s;

    assign nmi_edge_s = nmi_prev_q & ~i_nmi_x;
    // Wired-OR of the active-low lines, gated by the I flag.
    assign irq_req_s  = ~(&i_irq_x) & ~rf2il_psr[2];

    // Vector selection and the PSR image pushed for the current source.
    always_comb begin
        vector_s   = VEC_IRQ;
        push_psr_s = (rf2il_psr & 8'hef) | 8'h20;
        case (src_q)
            SRC_RES: vector_s = VEC_RES;
            SRC_NMI: vector_s = VEC_NMI;
            SRC_BRK: begin
                vector_s   = VEC_IRQ;
                push_psr_s = rf2il_psr | 8'h30;
            end
            SRC_IRQ: vector_s = VEC_IRQ;
            default: vector_s = VEC_IRQ;
        endcase
    end

    // Next-state, source and NMI-pending logic.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        nmi_clear_s = 1'b0;
        nmi_prev_d  = i_nmi_x;
        case (state_q)
            ST_IDLE: begin
                if (cs2il_fetch || cs2il_brk) begin
                    if (cs2il_brk) begin
                        src_d   = SRC_BRK;
                        state_d = ST_PUSH_PCH;
                    end else if (nmi_pending_q) begin
                        src_d   = SRC_NMI;
                        state_d = ST_PUSH_PCH;
                    end else if (irq_req_s) begin
                        src_d   = SRC_IRQ;
                        state_d = ST_PUSH_PCH;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PUSH_PCH: state_d = ST_PUSH_PCL;
            ST_PUSH_PCL: state_d = ST_PUSH_PSR;
            ST_PUSH_PSR: begin
                // Vector commit point: a pending NMI takes over whatever
                // source started the sequence; the pushed B bit does not.
                if (nmi_pending_q) begin
                    src_d       = SRC_NMI;
                    nmi_clear_s = 1'b1;
                end else begin
                    src_d = src_q;
                end
                state_d = ST_LOAD_PCL;
            end
            ST_LOAD_PCL: state_d = ST_LOAD_PCH;
            ST_LOAD_PCH: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
        // A fresh edge in the clearing cycle keeps the request alive.
        if (nmi_edge_s) begin
            nmi_pending_d = 1'b1;
        end else if (nmi_clear_s) begin
            nmi_pending_d = 1'b0;
        end else begin
            nmi_pending_d = nmi_pending_q;
        end
    end

    // Bus and register-file strobes decoded from the current state.
    always_comb begin
        il2cs_busy    = (state_q != ST_IDLE);
        il2cs_done    = 1'b0;
        il2mc_addr    = 16'h0000;
        il2mc_read    = 1'b0;
        il2mc_write   = 1'b0;
        il2mc_data    = 8'h00;
        il2rf_dec_s   = 1'b0;
        il2rf_set_i   = 1'b0;
        il2rf_set_pcl = 1'b0;
        il2rf_set_pch = 1'b0;
        il2rf_data    = mc2il_data;
        if (rst) begin
            il2cs_busy = 1'b1;
            il2rf_data = 8'h00;
        end else begin
            case (state_q)
                ST_PUSH_PCH, ST_PUSH_PCL, ST_PUSH_PSR: begin
                    il2mc_write = 1'b1;
                    il2mc_addr  = {STACK_PAGE, rf2il_s};
                    il2rf_dec_s = 1'b1;
                    if (state_q == ST_PUSH_PCH) begin
                        il2mc_data = rf2il_pc[15:8];
                    end else if (state_q == ST_PUSH_PCL) begin
                        il2mc_data = rf2il_pc[7:0];
                    end else begin
                        il2mc_data = push_psr_s;
                    end
                end
                ST_LOAD_PCL: begin
                    il2mc_read    = 1'b1;
                    il2mc_addr    = vector_s;
                    il2rf_set_pcl = 1'b1;
                    il2rf_set_i   = 1'b1;
                end
                ST_LOAD_PCH: begin
                    il2mc_read    = 1'b1;
                    il2mc_addr    = vector_s + 16'd1;
                    il2rf_set_pch = 1'b1;
                    il2cs_done    = 1'b1;
                end
                default: il2mc_addr = 16'h0000;
            endcase
        end
    end

    // State registers; reset parks the sequencer on the RES vector fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_LOAD_PCL;
            src_q         <= SRC_RES;
            nmi_pending_q <= 1'b0;
            nmi_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            nmi_pending_q <= nmi_pending_d;
            nmi_prev_q    <= nmi_prev_d;
        end
    end

endmodule

// File: tb/tb_mc6502_interrupt_sequencer.sv
// Directed bench for mc6502_interrupt_sequencer. Two instances: default
// parameters, and STACK_PAGE=02 / VECTOR_BASE=ff00 / N_IRQ=4. Expected bus
// transactions are queued when stimulus is driven and popped on each strobe.
module tb_mc6502_interrupt_sequencer;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    ev_t  q1[$];
    ev_t  q2[$];
    logic [7:0] rom [0:65535];

    // Instance 1 signals
    logic [0:0]  irq1;
    logic        nmi1, fetch1, brk1, busy1, done1, r1, w1;
    logic        dec1, seti1, pcl1, pch1;
    logic [15:0] a1, pc1;
    logic [7:0]  md1, wd1, rfd1, s1, psr1;

    // Instance 2 signals
    logic [3:0]  irq2;
    logic        fetch2, busy2, done2, r2, w2;
    logic        dec2, seti2, pcl2, pch2;
    logic [15:0] a2;
    logic [7:0]  md2, wd2, rfd2, s2;

    // Register-file model load controls
    logic        ld1, ld2;
    logic [7:0]  ld_s, ld_psr;
    logic [15:0] ld_pc;

    assign md1 = rom[a1];
    assign md2 = rom[a2];

    mc6502_interrupt_sequencer u_dut1 (
        .clk(clk), .rst(rst), .i_irq_x(irq1), .i_nmi_x(nmi1),
        .cs2il_fetch(fetch1), .cs2il_brk(brk1),
        .il2cs_busy(busy1), .il2cs_done(done1),
        .mc2il_data(md1), .il2mc_addr(a1), .il2mc_read(r1),
        .il2mc_write(w1), .il2mc_data(wd1),
        .rf2il_s(s1), .rf2il_psr(psr1), .rf2il_pc(pc1),
        .il2rf_dec_s(dec1), .il2rf_set_i(seti1), .il2rf_data(rfd1),
        .il2rf_set_pcl(pcl1), .il2rf_set_pch(pch1)
    );

    mc6502_interrupt_sequencer #(
        .N_IRQ(4), .STACK_PAGE(8'h02), .VECTOR_BASE(16'hff00)
    ) u_dut2 (
        .clk(clk), .rst(rst), .i_irq_x(irq2), .i_nmi_x(1'b1),
        .cs2il_fetch(fetch2), .cs2il_brk(1'b0),
        .il2cs_busy(busy2), .il2cs_done(done2),
        .mc2il_data(md2), .il2mc_addr(a2), .il2mc_read(r2),
        .il2mc_write(w2), .il2mc_data(wd2),
        .rf2il_s(s2), .rf2il_psr(8'h00), .rf2il_pc(16'habcd),
        .il2rf_dec_s(dec2), .il2rf_set_i(seti2), .il2rf_data(rfd2),
        .il2rf_set_pcl(pcl2), .il2rf_set_pch(pch2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file model: applies the sequencer strobes at the clock edge.
    always @(posedge clk) begin
        if (ld1) begin
            s1   <= ld_s;
            pc1  <= ld_pc;
            psr1 <= ld_psr;
        end else begin
            if (dec1)  s1        <= s1 - 8'd1;
            if (seti1) psr1[2]   <= 1'b1;
            if (pcl1)  pc1[7:0]  <= rfd1;
            if (pch1)  pc1[15:8] <= rfd1;
        end
        if (ld2) s2 <= ld_s;
        else if (dec2) s2 <= s2 - 8'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_ev(input int sel, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        e = '{wr: wr, addr: addr, data: data};
        if (sel == 0) q1.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic chk_ev(input int sel, input logic wr, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        int  sz;
        sz = (sel == 0) ? q1.size() : q2.size();
        check("bus_expected", {31'd0, sz != 0}, 32'd1);
        if (sz != 0) begin
            if (sel == 0) e = q1.pop_front();
            else e = q2.pop_front();
            check("bus_kind", {31'd0, wr}, {31'd0, e.wr});
            check("bus_addr", {16'd0, addr}, {16'd0, e.addr});
            check("bus_data", {24'd0, data}, {24'd0, e.data});
        end
    endtask

    // One clock: scoreboard bus strobes on the falling edge, return 1 after the rising edge.
    task automatic cyc();
        @(negedge clk);
        if (!rst) begin
            if (w1 || r1) chk_ev(0, w1, a1, w1 ? wd1 : rfd1);
            if (w2 || r2) chk_ev(1, w2, a2, w2 ? wd2 : rfd2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [7:0] s, input logic [15:0] pc, input logic [7:0] psr);
        ld1 = 1'b1; ld_s = s; ld_pc = pc; ld_psr = psr;
        cyc();
        ld1 = 1'b0;
    endtask

    // Trigger is driven in the current cycle; checks 5 busy cycles with done in the last.
    task automatic take(input int sel, input int nmi_at);
        cyc();
        fetch1 = 1'b0; brk1 = 1'b0; fetch2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == nmi_at) nmi1 = 1'b0;
            #1;
            check("seq_busy", {31'd0, (sel == 0) ? busy1 : busy2}, 32'd1);
            check("seq_done", {31'd0, (sel == 0) ? done1 : done2}, {31'd0, i == 4});
            cyc();
        end
        #1;
        check("seq_idle", {31'd0, (sel == 0) ? busy1 : busy2}, 32'd0);
    endtask

    task automatic idle_fetches(input string tag);
        fetch1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check(tag, {30'd0, busy1, w1}, 32'd0);
            cyc();
        end
        fetch1 = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1;
        irq1 = 1'b1; nmi1 = 1'b1; fetch1 = 1'b0; brk1 = 1'b0;
        irq2 = 4'hf; fetch2 = 1'b0;
        ld1 = 1'b0; ld2 = 1'b0; ld_s = 8'h00; ld_pc = 16'h0000; ld_psr = 8'h00;
        rom[16'hfffc] = 8'h34; rom[16'hfffd] = 8'h12;
        rom[16'hfffe] = 8'h78; rom[16'hffff] = 8'h56;
        rom[16'hfffa] = 8'hcd; rom[16'hfffb] = 8'hab;
        rom[16'hff02] = 8'h11; rom[16'hff03] = 8'h22;
        rom[16'hff04] = 8'h44; rom[16'hff05] = 8'h33;
        rom[16'h0000] = 8'h00;
        @(posedge clk); #1;

        // Held in reset: busy only.
        for (int i = 0; i < 2; i++) begin
            #1;
            check("rst_busy", {31'd0, busy1}, 32'd1);
            check("rst_strobes", {26'd0, r1, w1, done1, dec1, seti1, pcl1}, 32'd0);
            check("rst_addr", {16'd0, a1}, 32'd0);
            check("rst_rfdata", {24'd0, rfd1}, 32'd0);
            cyc();
        end

        // Reset vector fetch.
        exp_ev(0, 1'b0, 16'hfffc, 8'h34);
        exp_ev(0, 1'b0, 16'hfffd, 8'h12);
        exp_ev(1, 1'b0, 16'hff02, 8'h11);
        exp_ev(1, 1'b0, 16'hff03, 8'h22);
        rst = 1'b0;
        #1;
        check("res_c1_done", {30'd0, busy1, done1}, 32'd2);
        cyc();
        #1;
        check("res_c2_done", {30'd0, busy1, done1}, 32'd3);
        cyc();
        #1;
        check("res_c3_busy", {31'd0, busy1}, 32'd0);
        check("res_pc", {16'd0, pc1}, 32'h1234);
        check("res_i", {31'd0, psr1[2]}, 32'd1);

        // IRQ entry.
        load1(8'hff, 16'h8005, 8'h00);
        irq1 = 1'b0;
        fetch1 = 1'b1;
        exp_ev(0, 1'b1, 16'h01ff, 8'h80);
        exp_ev(0, 1'b1, 16'h01fe, 8'h05);
        exp_ev(0, 1'b1, 16'h01fd, 8'h20);
        exp_ev(0, 1'b0, 16'hfffe, 8'h78);
        exp_ev(0, 1'b0, 16'hffff, 8'h56);
        take(0, -1);
        check("irq_s", {24'd0, s1}, 32'hfc);
        check("irq_pc", {16'd0, pc1}, 32'h5678);
        check("irq_i", {31'd0, psr1[2]}, 32'd1);

        // Masked IRQ is ignored, then taken once I is cleared.
        load1(8'hff, 16'h5678, 8'h04);
        idle_fetches("masked_irq");
        load1(8'hff, 16'h5678, 8'h00);
        fetch1 = 1'b1;
        exp_ev(0, 1'b1, 16'h01ff, 8'h56);
        exp_ev(0, 1'b1, 16'h01fe, 8'h78);
        exp_ev(0, 1'b1, 16'h01fd, 8'h20);
        exp_ev(0, 1'b0, 16'hfffe, 8'h78);
        exp_ev(0, 1'b0, 16'hffff, 8'h56);
        take(0, -1);

        // BRK beats IRQ.
        load1(8'hff, 16'h1000, 8'h01);
        brk1 = 1'b1; fetch1 = 1'b1;
        exp_ev(0, 1'b1, 16'h01ff, 8'h10);
        exp_ev(0, 1'b1, 16'h01fe, 8'h00);
        exp_ev(0, 1'b1, 16'h01fd, 8'h31);
        exp_ev(0, 1'b0, 16'hfffe, 8'h78);
        exp_ev(0, 1'b0, 16'hffff, 8'h56);
        take(0, -1);
        irq1 = 1'b1;

        // NMI hijacks a BRK; B stays set in the pushed PSR.
        load1(8'hff, 16'h2000, 8'h04);
        brk1 = 1'b1;
        exp_ev(0, 1'b1, 16'h01ff, 8'h20);
        exp_ev(0, 1'b1, 16'h01fe, 8'h00);
        exp_ev(0, 1'b1, 16'h01fd, 8'h34);
        exp_ev(0, 1'b0, 16'hfffa, 8'hcd);
        exp_ev(0, 1'b0, 16'hfffb, 8'hab);
        take(0, 1);
        check("hijack_pc", {16'd0, pc1}, 32'habcd);
        check("hijack_s", {24'd0, s1}, 32'hfc);
        idle_fetches("nmi_held_low");

        // Fresh NMI edge: pushed PSR has B cleared, bit 5 set.
        nmi1 = 1'b1;
        cyc();
        load1(8'hff, 16'h3000, 8'h1c);
        nmi1 = 1'b0;
        cyc();
        fetch1 = 1'b1;
        exp_ev(0, 1'b1, 16'h01ff, 8'h30);
        exp_ev(0, 1'b1, 16'h01fe, 8'h00);
        exp_ev(0, 1'b1, 16'h01fd, 8'h2c);
        exp_ev(0, 1'b0, 16'hfffa, 8'hcd);
        exp_ev(0, 1'b0, 16'hfffb, 8'hab);
        take(0, -1);
        nmi1 = 1'b1;

        // Non-default parameters with stack wrap inside page 02.
        ld2 = 1'b1; ld_s = 8'h00;
        cyc();
        ld2 = 1'b0;
        irq2 = 4'b1011;
        fetch2 = 1'b1;
        exp_ev(1, 1'b1, 16'h0200, 8'hab);
        exp_ev(1, 1'b1, 16'h02ff, 8'hcd);
        exp_ev(1, 1'b1, 16'h02fe, 8'h20);
        exp_ev(1, 1'b0, 16'hff04, 8'h44);
        exp_ev(1, 1'b0, 16'hff05, 8'h33);
        take(1, -1);
        check("p2_s", {24'd0, s2}, 32'hfd);
        irq2 = 4'hf;
        cyc();

        check("q1_drained", q1.size(), 32'd0);
        check("q2_drained", q2.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc6502_interrupt_sequencer.md
# mc6502_interrupt_sequencer

Parametrised interrupt sequencer for the MC6502 core, sitting between the core sequencer, the register file and the memory controller. It arbitrates RES, NMI (edge), BRK and N maskable IRQ lines. At an instruction boundary it runs the full push sequence: PCH, PCL and PSR to the stack, then a two-byte vector fetch. It supports NMI hijack of BRK/IRQ and a configurable stack page and vector base.

## Interface
- N_IRQ, 1: number of active-low IRQ inputs, wired-OR; valid range 1..8.
- STACK_PAGE, 8'h01: high address byte for stack writes.
- VECTOR_BASE, 16'hfffa: NMI vector address. RES vector = base+2, IRQ/BRK vector = base+4. 16-bit wrap-around add.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- i_irq_x  in  N_IRQ  level IRQ requests, active-low
- i_nmi_x  in  1  NMI request, active-low, falling-edge sensitive
- cs2il_fetch  in  1  pulse: core is at an opcode-fetch boundary, interrupt may be taken
- cs2il_brk  in  1  pulse: BRK decoded, PC already advanced by core
- il2cs_busy  out  1  sequence in progress, core stalls
- il2cs_done  out  1  pulse in final sequence cycle
- mc2il_data  in  8  read data, combinational same cycle
- il2mc_addr  out  16  bus address
- il2mc_read  out  1  vector read strobe
- il2mc_write  out  1  stack write strobe
- il2mc_data  out  8  write data
- rf2il_s  in  8  stack pointer
- rf2il_psr  in  8  status register, bit2 = I
- rf2il_pc  in  16  program counter
- il2rf_dec_s  out  1  decrement S at this edge
- il2rf_set_i  out  1  set I flag at this edge
- il2rf_data  out  8  = mc2il_data
- il2rf_set_pcl  out  1  load PC[7:0] from il2rf_data
- il2rf_set_pch  out  1  load PC[15:8] from il2rf_data

## Operation
- States: IDLE, PUSH_PCH, PUSH_PCL, PUSH_PSR, LOAD_PCL, LOAD_PCH.
- Source register: RES, NMI, BRK or IRQ.
- NMI detect:
  - r_nmi_prev samples i_nmi_x each cycle.
  - prev=1 and now=0 sets nmi_pending.
  - Pending clears when the vector is committed to NMI.
  - A new edge in the same cycle as the clear wins, so pending stays 1.
  - A held-low NMI never retriggers.
- IRQ request = any bit of i_irq_x low AND rf2il_psr[2]==0.
- IDLE arbitration, evaluated only when cs2il_fetch or cs2il_brk is high:
  - Priority: cs2il_brk > nmi_pending > IRQ.
  - A winner moves the state to PUSH_PCH. With no winner, stay in IDLE.
- PUSH_PCH / PUSH_PCL / PUSH_PSR:
  - il2mc_write=1, il2mc_addr={STACK_PAGE, rf2il_s}, il2rf_dec_s=1.
  - Data, in order: PC[15:8], PC[7:0], pushed PSR.
  - Pushed PSR for BRK = psr|8'h30.
  - Pushed PSR for NMI/IRQ = (psr&8'hef)|8'h20.
- Hijack: in the PUSH_PSR cycle, if nmi_pending=1 the committed vector becomes NMI, whatever the source. The pushed B bit keeps the original source.
- LOAD_PCL: il2mc_read=1, addr=vector, il2rf_set_pcl=1, il2rf_set_i=1.
- LOAD_PCH: il2mc_read=1, addr=vector+1, il2rf_set_pch=1, il2cs_done=1. Next state is IDLE.
- Reset sequence:
  - Reset enters LOAD_PCL with the RES vector. There are no pushes, and S is unchanged.
  - il2rf_set_i=1 in LOAD_PCL.
  - nmi_pending=0; r_nmi_prev=1.
- cs2il_fetch and cs2il_brk are ignored outside IDLE.
- IRQ is level-sensitive: an IRQ that deasserts before a boundary is lost, with no latching.

## Timing
- While rst=1:
  - il2cs_busy=1.
  - All other outputs 0, addr 16'h0000.
  - State is held at LOAD_PCL/RES.
- First cycle after rst falls: LOAD_PCL (addr base+2, i.e. 16'hfffc by default). Second cycle: LOAD_PCH (16'hfffd, done=1). Third cycle: IDLE.
- Interrupt latency: take at a boundary edge, then exactly 5 busy cycles (3 writes + 2 reads). done is in the 5th.
- il2cs_busy=1 in every non-IDLE state. It falls on the edge leaving LOAD_PCH.
- The register file applies dec_s, set_pcl, set_pch and set_i at the same rising edge. Each push cycle sees the already-decremented S.
- Stack address wraps within the page: S=8'h00 writes {STACK_PAGE,8'h00}, then S becomes 8'hff.
- rst asserted mid-sequence aborts the sequence on the next edge. Partial pushes stay in memory.

## Test plan
- Reset: default parameters, memory fffc=34 fffd=12; release rst -> read fffc then fffd, PC=16'h1234, I=1, done in cycle 2, busy low in cycle 3.
- IRQ: PC=16'h8005, S=ff, psr=8'h00, i_irq_x[0]=0, fetch pulse -> writes 01ff=80, 01fe=05, 01fd=20; reads fffe/ffff; S=fc; I set; 5 busy cycles.
- Masked IRQ: psr=8'h04, IRQ low, fetch pulses -> no write, busy stays 0. Clearing I then pulsing fetch -> sequence starts.
- BRK beats IRQ: brk and fetch together with IRQ low, psr=8'h01 -> pushed PSR=31, vector fffe.
- NMI hijack: BRK sequence, NMI falling edge during PUSH_PCL -> pushed PSR has B=1, vector fffa/fffb, nmi_pending cleared. NMI held low afterwards -> no second NMI.
- Parameters: STACK_PAGE=8'h02, VECTOR_BASE=16'hff00, N_IRQ=4, i_irq_x=4'b1011, S=00 -> pushes 0200, 02ff, 02fe; vector ff04/ff05.
